// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
//   seq_state_t : sequencer FSM states
//   PC_W_DEF    : default program-counter width
//   OFF_W/CNT_W : branch-offset and instruction-count widths
//   sat_inc     : saturating increment for the instruction counter
package fetch_sequencer_pkg;

  localparam int PC_W_DEF = 10;
  localparam int OFF_W    = 6;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    DONE
  } seq_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its environment (decoder, datapath, ROM).
//   master : the sequencer -- drives ROM strobe/address, pc, status, count
//   slave  : the environment -- drives start, decoded control and stall
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic             start;
  logic             halt;
  logic             jump_en;
  logic             branch_en;
  logic [PC_W-1:0]  target;
  logic [OFF_W-1:0] offset;
  logic             stall;
  logic             rom_rd;
  logic [PC_W-1:0]  rom_addr;
  logic             instr_valid;
  logic [PC_W-1:0]  pc;
  logic             done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, halt, jump_en, branch_en, target, offset, stall,
    output rom_rd, rom_addr, instr_valid, pc, done, instr_count
  );

  modport slave (
    output start, halt, jump_en, branch_en, target, offset, stall,
    input  rom_rd, rom_addr, instr_valid, pc, done, instr_count
  );

endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// Combinational next-PC selection.
//   pc, target      : current pc and absolute jump target
//   offset          : signed branch offset (sign-extended to PC_W)
//   halt/jump/branch: decoded control, priority halt > jump > branch > +1
//   pc_next         : selected next pc, wraps modulo 2^PC_W
// PC_W must be wider than the offset field.
module next_pc
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  target,
  input  logic [OFF_W-1:0] offset,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic             halt,
  output logic [PC_W-1:0]  pc_next
);

  logic [PC_W-1:0] off_ext;

  assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

  // Truncation to PC_W gives the modulo-2^PC_W wrap in both directions.
  always_comb begin
    pc_next = pc + 1'b1;
    if (halt)           pc_next = pc;
    else if (jump_en)   pc_next = target;
    else if (branch_en) pc_next = pc + off_ext;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> [WAIT] -> EXEC -> FETCH/DONE.
//   CLK, Reset_n : clock, asynchronous active-low reset
//   bus (master) : start/halt/jump/branch/target/offset/stall in;
//                  rom_rd, rom_addr(=pc), instr_valid, pc, done, instr_count out
// ROM_LAT is the ROM read latency, 1..4 cycles; each instruction takes
// ROM_LAT+1 cycles fetch-to-fetch without stalls. All outputs are registered.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic CLK,
  input  logic Reset_n,
  fetch_sequencer_if.master bus
);

  // WAIT lasts ROM_LAT-1 cycles: load ROM_LAT-2 and leave on zero.
  localparam int WAIT_LOAD = (ROM_LAT > 1) ? ROM_LAT - 2 : 0;

  seq_state_t       state;
  logic [1:0]       wait_cnt;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             rom_rd_q;
  logic             vld_q;
  logic             done_q;

  next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc        (pc_q),
    .target    (bus.target),
    .offset    (bus.offset),
    .jump_en   (bus.jump_en),
    .branch_en (bus.branch_en),
    .halt      (bus.halt),
    .pc_next   (pc_nxt)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      rom_rd_q <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= FETCH;
            pc_q     <= '0;
            cnt_q    <= '0;
            rom_rd_q <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        FETCH: begin
          rom_rd_q <= 1'b0;
          if (ROM_LAT == 1) begin
            state <= EXEC;
            vld_q <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= 2'(WAIT_LOAD);
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= EXEC;
            vld_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        EXEC: begin
          // Stall holds everything; decoded control is only sampled on exit.
          if (!bus.stall) begin
            cnt_q <= sat_inc(cnt_q);
            pc_q  <= pc_nxt;
            vld_q <= 1'b0;
            if (bus.halt) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state    <= FETCH;
              rom_rd_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_rd      = rom_rd_q;
  assign bus.rom_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = vld_q;
  assign bus.done        = done_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: ROM_LAT=1 instance (sa) for sequencing, priority, wrap,
// stall and ignore rules; ROM_LAT=3 instance (sb) for latency and reset abort.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(10)) sa ();
  fetch_sequencer_if #(.PC_W(10)) sb ();

  fetch_sequencer #(.PC_W(10), .ROM_LAT(1)) dut1 (.CLK(clk), .Reset_n(rst_n), .bus(sa));
  fetch_sequencer #(.PC_W(10), .ROM_LAT(3)) dut3 (.CLK(clk), .Reset_n(rst_n), .bus(sb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge with sa in FETCH; leaves at the negedge after EXEC exit.
  task automatic run_instr(input string tag, input logic [9:0] exp_pc,
                           input logic h, input logic j, input logic br,
                           input logic [9:0] tg, input logic [5:0] off);
    chk({tag, "_rd"},   32'(sa.rom_rd), 32'd1);
    chk({tag, "_addr"}, 32'(sa.rom_addr), 32'(exp_pc));
    step();
    chk({tag, "_vld"},  32'(sa.instr_valid), 32'd1);
    chk({tag, "_pc"},   32'(sa.pc), 32'(exp_pc));
    sa.halt = h; sa.jump_en = j; sa.branch_en = br; sa.target = tg; sa.offset = off;
    step();
    sa.halt = 1'b0; sa.jump_en = 1'b0; sa.branch_en = 1'b0; sa.target = '0; sa.offset = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sa.start = 0; sa.halt = 0; sa.jump_en = 0; sa.branch_en = 0;
    sa.target = '0; sa.offset = '0; sa.stall = 0;
    sb.start = 0; sb.halt = 0; sb.jump_en = 0; sb.branch_en = 0;
    sb.target = '0; sb.offset = '0; sb.stall = 0;

    // Reset state
    step();
    chk("rst_pc",   32'(sa.pc), 32'd0);
    chk("rst_rd",   32'(sa.rom_rd), 32'd0);
    chk("rst_vld",  32'(sa.instr_valid), 32'd0);
    chk("rst_done", 32'(sa.done), 32'd0);
    chk("rst_cnt",  32'(sa.instr_count), 32'd0);
    chk("rst_b_rd", 32'(sb.rom_rd), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_rd", 32'(sa.rom_rd), 32'd0);

    // Straight line, halt on the 5th instruction
    sa.start = 1; step(); sa.start = 0;
    run_instr("sl0", 10'd0, 0, 0, 0, 10'd0, 6'd0);
    run_instr("sl1", 10'd1, 0, 0, 0, 10'd0, 6'd0);
    run_instr("sl2", 10'd2, 0, 0, 0, 10'd0, 6'd0);
    run_instr("sl3", 10'd3, 0, 0, 0, 10'd0, 6'd0);
    run_instr("sl4", 10'd4, 1, 0, 0, 10'd0, 6'd0);
    chk("sl_done", 32'(sa.done), 32'd1);
    chk("sl_pc",   32'(sa.pc), 32'd4);
    chk("sl_cnt",  32'(sa.instr_count), 32'd5);
    chk("sl_rd",   32'(sa.rom_rd), 32'd0);
    step();
    chk("sl_hold", 32'(sa.done), 32'd1);

    // Restart from DONE, then priority and wrap
    sa.start = 1; step(); sa.start = 0;
    chk("rs_cnt",  32'(sa.instr_count), 32'd0);
    chk("rs_done", 32'(sa.done), 32'd0);
    run_instr("p0", 10'd0, 0, 0, 0, 10'd0, 6'd0);
    run_instr("p1", 10'd1, 0, 0, 0, 10'd0, 6'd0);
    run_instr("p2", 10'd2, 0, 0, 0, 10'd0, 6'd0);
    run_instr("p3", 10'd3, 0, 1, 1, 10'd40, 6'h3E);    // jump wins over branch
    run_instr("p40", 10'd40, 0, 0, 1, 10'd0, 6'h3E);   // 40 - 2
    run_instr("p38", 10'd38, 0, 1, 0, 10'd1023, 6'd0);
    run_instr("w1023", 10'd1023, 0, 0, 0, 10'd0, 6'd0); // 1023 + 1 -> 0
    run_instr("w0", 10'd0, 0, 0, 1, 10'd0, 6'h3F);      // 0 - 1 -> 1023
    run_instr("w1023b", 10'd1023, 0, 1, 0, 10'd7, 6'd0);
    chk("w_cnt", 32'(sa.instr_count), 32'd9);

    // Stall at pc 7: three stalled cycles plus the executing one
    chk("st_rd", 32'(sa.rom_rd), 32'd1);
    step();
    sa.stall = 1; sa.jump_en = 1; sa.target = 10'd100; sa.start = 1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("st_vld%0d", k), 32'(sa.instr_valid), 32'd1);
      chk($sformatf("st_pc%0d", k),  32'(sa.pc), 32'd7);
      step();
    end
    chk("st_vld3", 32'(sa.instr_valid), 32'd1);
    chk("st_pc3",  32'(sa.pc), 32'd7);
    chk("st_cnt",  32'(sa.instr_count), 32'd9);
    sa.stall = 0; sa.jump_en = 0; sa.target = '0;
    step();
    sa.start = 0;
    chk("st_next", 32'(sa.pc), 32'd8);
    chk("st_cnt1", 32'(sa.instr_count), 32'd10);
    chk("st_fvld", 32'(sa.instr_valid), 32'd0);

    // Control outside EXEC is ignored
    sa.halt = 1; sa.jump_en = 1; sa.target = 10'd5;
    step();
    chk("ig_pc", 32'(sa.pc), 32'd8);
    sa.halt = 0; sa.jump_en = 0; sa.target = '0;
    step();
    chk("ig_next", 32'(sa.pc), 32'd9);
    chk("ig_done", 32'(sa.done), 32'd0);

    // ROM_LAT=3: rom_rd every 4 cycles, instr_valid 3 cycles after it
    sb.start = 1; step(); sb.start = 0;
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("lat_rd%0d", c),  32'(sb.rom_rd), 32'(c % 4 == 0));
      chk($sformatf("lat_vld%0d", c), 32'(sb.instr_valid), 32'(c % 4 == 3));
      chk($sformatf("lat_pc%0d", c),  32'(sb.pc), 32'(c / 4));
      if (c < 49) step();
    end
    chk("lat_cnt", 32'(sb.instr_count), 32'd12);

    // Reset during WAIT at pc 12 takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc",   32'(sb.pc), 32'd0);
    chk("ar_cnt",  32'(sb.instr_count), 32'd0);
    chk("ar_rd",   32'(sb.rom_rd), 32'd0);
    chk("ar_vld",  32'(sb.instr_valid), 32'd0);
    chk("ar_done", 32'(sb.done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_idle", 32'(sb.rom_rd), 32'd0);
    sb.start = 1; step(); sb.start = 0;
    chk("ar_rd1",  32'(sb.rom_rd), 32'd1);
    chk("ar_pc1",  32'(sb.pc), 32'd0);
    step(); step(); step();
    chk("ar_vld1", 32'(sb.instr_valid), 32'd1);
    chk("ar_cnt1", 32'(sb.instr_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width in bits.
REQ-002 SHALL have parameter ROM_LAT, default 1, instruction-ROM read latency in cycles (1..4).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  begin program execution from PC 0.
REQ-006 SHALL have port halt  input  1  decoded halt instruction, qualified by instr_valid.
REQ-007 SHALL have port jump_en  input  1  from control decoder: take absolute jump.
REQ-008 SHALL have port branch_en  input  1  from control decoder: take relative branch.
REQ-009 SHALL have port target  input  PC_W  absolute jump target (from LUT).
REQ-010 SHALL have port offset  input  6  signed two's-complement branch offset.
REQ-011 SHALL have port stall  input  1  datapath busy; hold current instruction.
REQ-012 SHALL have port rom_rd  output  1  ROM read strobe.
REQ-013 SHALL have port rom_addr  output  PC_W  ROM address, equals pc.
REQ-014 SHALL have port instr_valid  output  1  ROM data valid, instruction executing this cycle.
REQ-015 SHALL have port pc  output  PC_W  current program counter.
REQ-016 SHALL have port done  output  1  program halted.
REQ-017 SHALL have port instr_count  output  16  executed-instruction count.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WAIT, EXEC, DONE.
REQ-019 IDLE: all strobes 0; start=1 -> FETCH with pc=0, instr_count=0.
REQ-020 FETCH: rom_rd=1 for exactly one cycle; -> EXEC if ROM_LAT=1, else -> WAIT.
REQ-021 WAIT: rom_rd=0; internal counter holds ROM_LAT-1 cycles, then -> EXEC.
REQ-022 EXEC: instr_valid=1; stall=1 -> remain in EXEC, pc and count unchanged, next-PC inputs ignored.
REQ-023 EXEC with stall=0: instr_count increments (saturates at 0xFFFF); next pc per REQ-024; -> FETCH, or -> DONE if halt=1.
REQ-024 Next-PC priority: halt (pc held) > jump_en (pc=target) > branch_en (pc=pc+sign_extend(offset)) > pc+1.
REQ-025 jump_en and branch_en both 1: jump taken, branch ignored.
REQ-026 PC arithmetic SHALL wrap modulo 2^PC_W (pc max +1 -> 0; pc 0 + offset -1 -> max).
REQ-027 Fetch-to-fetch latency: ROM_LAT+1 cycles per instruction with no stall.
REQ-028 DONE: done=1 held; start=1 -> FETCH with pc=0, count=0 (restart).
REQ-029 start while in FETCH, WAIT or EXEC SHALL be ignored.
REQ-030 halt, jump_en, branch_en SHALL be ignored outside EXEC.
REQ-031 rom_addr SHALL equal pc in every cycle; pc changes only on EXEC exit or start.

Reset
REQ-032 Reset_n=0 SHALL force state IDLE, pc=0, instr_count=0, wait counter 0, all outputs 0, asynchronously.
REQ-033 Reset asserted mid-fetch or mid-stall SHALL abort the instruction with no count increment; first post-reset edge sees IDLE.

Structure
REQ-034 Shared package definitions SHALL hold seq_state_t (enum of REQ-018 states) and default PC_W constant.
REQ-035 Next-PC selection SHALL be a combinational sub-module next_pc (inputs pc, target, offset, jump_en, branch_en, halt; output PC_W next value).
REQ-036 FSM, wait counter, pc and instr_count registers SHALL reside in fetch_sequencer; one always_ff, reset in sensitivity list.

Verification
REQ-037 Straight-line: start, no branches, ROM_LAT=1, halt at 5th instruction -> pc 0,1,2,3,4; done=1; instr_count=5.
REQ-038 Jump/branch priority: at pc=3 jump_en=1, branch_en=1, target=40, offset=-2 -> next pc=40; at pc=40 branch_en=1, offset=-2 -> pc=38.
REQ-039 Wrap: PC_W=10, pc=1023 no branch -> pc=0; pc=0 branch offset=-1 -> pc=1023.
REQ-040 Stall: stall=1 for 3 cycles in EXEC at pc=7 -> instr_valid high 4 cycles, pc stays 7, count +1 only once.
REQ-041 Latency: ROM_LAT=3 -> rom_rd pulses every 4 cycles; instr_valid exactly 3 cycles after each rom_rd.
REQ-042 Reset mid-op: Reset_n low during WAIT at pc=12 -> immediate IDLE, pc=0, count=0; subsequent start restarts at pc 0.
